mem_arbiter: RTL and testbench

- Sequences a single-port unified memory between the fetch stage and the load/store path of the pipeline.
- Arbitrates between the two requesters and launches one memory transaction at a time.
- Tracks the outstanding response, returns it to the owning requester and raises a timeout error if memory never answers.
- Data-side accesses have priority; a starvation guard bounds how long fetch can be locked out.

---
 rtl/mem_arbiter_pkg.sv | 17 +
 rtl/mem_arbiter.sv | 124 ++++++++++++
 tb/tb_mem_arbiter.sv | 323 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_pkg.sv
// Shared types for the unified-memory arbiter.
// Access sizes and arbiter FSM states.
package mem_arbiter_pkg;

  typedef enum logic [1:0] {
    SIZE_BYTE = 2'b00,
    SIZE_HALF = 2'b01,
    SIZE_WORD = 2'b10
  } mem_size_t;

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    WAIT_IF = 2'b01,
    WAIT_D  = 2'b10
  } arb_state_t;

endpackage

// File: rtl/mem_arbiter.sv
// Single-port memory arbiter: fetch vs load/store, one transaction
// in flight, data priority with a starvation guard and a response timeout.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int AWIDTH     = 32,
  parameter int DWIDTH     = 32,
  parameter int STARVE_MAX = 4,
  parameter int TIMEOUT    = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req_i,
  input  logic [AWIDTH-1:0] if_addr_i,
  output logic              if_gnt_o,
  output logic              if_rvalid_o,
  output logic [DWIDTH-1:0] if_rdata_o,
  input  logic              d_req_i,
  input  logic              d_we_i,
  input  logic [AWIDTH-1:0] d_addr_i,
  input  logic [DWIDTH-1:0] d_wdata_i,
  input  logic [1:0]        d_size_i,
  output logic              d_gnt_o,
  output logic              d_rvalid_o,
  output logic [DWIDTH-1:0] d_rdata_o,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [AWIDTH-1:0] mem_addr_o,
  output logic [DWIDTH-1:0] mem_wdata_o,
  output logic [1:0]        mem_size_o,
  input  logic              mem_rvalid_i,
  input  logic [DWIDTH-1:0] mem_rdata_i,
  output logic              busy_o,
  output logic              err_o
);

  localparam int SW = $clog2(STARVE_MAX + 1);
  localparam int TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);
  localparam logic [TW-1:0] TIME_LIM   = TW'(TIMEOUT - 1);

  arb_state_t  r_state;
  arb_state_t  w_next;
  logic [SW-1:0] r_starve;
  logic [TW-1:0] r_timer;
  logic          r_d_we;

  logic w_idle;
  logic w_d_win;
  logic w_if_win;
  logic w_wait_if;
  logic w_wait_d;
  logic w_wait;
  logic w_last;
  logic w_done;

  // Every decode is gated by reset so all outputs read 0 while it is held.
  assign w_idle    = reset && (r_state == IDLE);
  assign w_wait_if = reset && (r_state == WAIT_IF);
  assign w_wait_d  = reset && (r_state == WAIT_D);
  assign w_wait    = w_wait_if | w_wait_d;

  assign w_d_win  = w_idle && d_req_i &&
                    (!if_req_i || (r_starve < STARVE_LIM));
  assign w_if_win = w_idle && !w_d_win && if_req_i;

  assign w_last = (r_timer == TIME_LIM);
  assign w_done = mem_rvalid_i || w_last;

  assign mem_req_o   = w_d_win | w_if_win;
  assign mem_we_o    = w_d_win & d_we_i;
  assign mem_addr_o  = w_d_win  ? d_addr_i  :
                       w_if_win ? if_addr_i : '0;
  assign mem_wdata_o = w_d_win  ? d_wdata_i : '0;
  assign mem_size_o  = w_d_win  ? d_size_i  :
                       w_if_win ? SIZE_WORD : 2'b00;

  assign if_gnt_o = w_if_win;
  assign d_gnt_o  = w_d_win;

  assign if_rvalid_o = w_wait_if && w_done;
  assign if_rdata_o  = (w_wait_if && mem_rvalid_i) ? mem_rdata_i : '0;
  assign d_rvalid_o  = w_wait_d && w_done;
  assign d_rdata_o   = (w_wait_d && mem_rvalid_i && !r_d_we) ?
                       mem_rdata_i : '0;

  assign busy_o = w_wait;
  assign err_o  = w_wait && w_last && !mem_rvalid_i;

  always_comb begin
    w_next = r_state;
    unique case (1'b1)
      w_d_win:  w_next = WAIT_D;
      w_if_win: w_next = WAIT_IF;
      w_wait:   w_next = w_done ? IDLE : r_state;
      default:  w_next = r_state;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state  <= IDLE;
      r_starve <= '0;
      r_timer  <= '0;
      r_d_we   <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_d_win) begin
        r_d_we  <= d_we_i;
        r_timer <= '0;
        if (!if_req_i)
          r_starve <= '0;
        else if (r_starve != STARVE_LIM)
          r_starve <= r_starve + 1'b1;
      end else if (w_if_win) begin
        r_timer  <= '0;
        r_starve <= '0;
      end else if (w_wait) begin
        r_timer <= r_timer + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: a transaction table plus
// hand-written starvation, timeout and reset sequences.
module tb_mem_arbiter;
  import mem_arbiter_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        if_req_i;
  logic [31:0] if_addr_i;
  logic        if_gnt_o;
  logic        if_rvalid_o;
  logic [31:0] if_rdata_o;
  logic        d_req_i;
  logic        d_we_i;
  logic [31:0] d_addr_i;
  logic [31:0] d_wdata_i;
  logic [1:0]  d_size_i;
  logic        d_gnt_o;
  logic        d_rvalid_o;
  logic [31:0] d_rdata_o;
  logic        mem_req_o;
  logic        mem_we_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_wdata_o;
  logic [1:0]  mem_size_o;
  logic        mem_rvalid_i;
  logic [31:0] mem_rdata_i;
  logic        busy_o;
  logic        err_o;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  mem_arbiter #(
    .AWIDTH(32), .DWIDTH(32), .STARVE_MAX(4), .TIMEOUT(16)
  ) dut (
    .clk(clk), .reset(reset),
    .if_req_i(if_req_i), .if_addr_i(if_addr_i),
    .if_gnt_o(if_gnt_o), .if_rvalid_o(if_rvalid_o),
    .if_rdata_o(if_rdata_o),
    .d_req_i(d_req_i), .d_we_i(d_we_i), .d_addr_i(d_addr_i),
    .d_wdata_i(d_wdata_i), .d_size_i(d_size_i),
    .d_gnt_o(d_gnt_o), .d_rvalid_o(d_rvalid_o),
    .d_rdata_o(d_rdata_o),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o),
    .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
    .mem_size_o(mem_size_o),
    .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i),
    .busy_o(busy_o), .err_o(err_o)
  );

  // Requester rule: a request may not drop before it is granted.
  logic pend_if, pend_d;
  always @(posedge clk) begin
    if (!reset) begin
      pend_if <= 1'b0;
      pend_d  <= 1'b0;
    end else begin
      assert (!(pend_if && !if_req_i))
        else $error("protocol: if_req_i dropped before grant");
      assert (!(pend_d && !d_req_i))
        else $error("protocol: d_req_i dropped before grant");
      pend_if <= if_req_i && !if_gnt_o;
      pend_d  <= d_req_i && !d_gnt_o;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic        ifr;
    logic        dr;
    logic        we;
    logic [1:0]  sz;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          lat;
    logic [31:0] rdata;
    logic        exp_we;
    logic [1:0]  exp_sz;
    logic [31:0] exp_wdata;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t vecs[6];

  task automatic run_vec(input int i, input vec_t v);
    tick();
    if_req_i  = v.ifr;
    if_addr_i = v.ifr ? v.addr : 32'h0;
    d_req_i   = v.dr;
    d_addr_i  = v.dr ? v.addr : 32'hFFFF_0000;
    d_we_i    = v.we;
    d_size_i  = v.sz;
    d_wdata_i = v.wdata;
    @(negedge clk);
    chk($sformatf("v%0d.if_gnt", i), 32'(if_gnt_o), 32'(v.ifr));
    chk($sformatf("v%0d.d_gnt", i), 32'(d_gnt_o), 32'(v.dr));
    chk($sformatf("v%0d.mem_req", i), 32'(mem_req_o), 32'd1);
    chk($sformatf("v%0d.mem_addr", i), mem_addr_o, v.addr);
    chk($sformatf("v%0d.mem_we", i), 32'(mem_we_o), 32'(v.exp_we));
    chk($sformatf("v%0d.mem_size", i), 32'(mem_size_o), 32'(v.exp_sz));
    chk($sformatf("v%0d.mem_wdata", i), mem_wdata_o, v.exp_wdata);
    chk($sformatf("v%0d.busy_g", i), 32'(busy_o), 32'd0);
    for (int c = 1; c <= v.lat; c++) begin
      tick();
      if (c == 1) begin
        if_req_i = 1'b0;
        d_req_i  = 1'b0;
      end
      mem_rdata_i  = v.rdata;
      mem_rvalid_i = (c == v.lat);
      @(negedge clk);
      chk($sformatf("v%0d.busy_c%0d", i, c), 32'(busy_o), 32'd1);
      chk($sformatf("v%0d.mem_req_c%0d", i, c), 32'(mem_req_o), 32'd0);
      if (c < v.lat) begin
        chk($sformatf("v%0d.rv_early_c%0d", i, c),
            32'({if_rvalid_o, d_rvalid_o}), 32'd0);
      end else begin
        chk($sformatf("v%0d.if_rvalid", i), 32'(if_rvalid_o),
            32'(v.ifr));
        chk($sformatf("v%0d.d_rvalid", i), 32'(d_rvalid_o), 32'(v.dr));
        chk($sformatf("v%0d.if_rdata", i), if_rdata_o,
            v.ifr ? v.exp_rdata : 32'h0);
        chk($sformatf("v%0d.d_rdata", i), d_rdata_o,
            v.dr ? v.exp_rdata : 32'h0);
        chk($sformatf("v%0d.err", i), 32'(err_o), 32'd0);
      end
    end
    tick();
    mem_rvalid_i = 1'b0;
    @(negedge clk);
    chk($sformatf("v%0d.busy_end", i), 32'(busy_o), 32'd0);
    chk($sformatf("v%0d.rv_end", i),
        32'({if_rvalid_o, d_rvalid_o}), 32'd0);
  endtask

  initial begin
    vecs[0] = '{1'b1, 1'b0, 1'b1, SIZE_BYTE, 32'h0100_0000, 32'h77, 3,
                32'hDEAD_BEEF, 1'b0, SIZE_WORD, 32'h0, 32'hDEAD_BEEF};
    vecs[1] = '{1'b0, 1'b1, 1'b0, SIZE_WORD, 32'h0000_2000, 32'h99, 1,
                32'h1234_5678, 1'b0, SIZE_WORD, 32'h99, 32'h1234_5678};
    vecs[2] = '{1'b0, 1'b1, 1'b1, SIZE_BYTE, 32'h0000_0010, 32'hA5, 2,
                32'hFFFF_FFFF, 1'b1, SIZE_BYTE, 32'hA5, 32'h0};
    vecs[3] = '{1'b0, 1'b1, 1'b1, SIZE_HALF, 32'h0000_0022, 32'hBEEF, 1,
                32'h0000_1234, 1'b1, SIZE_HALF, 32'hBEEF, 32'h0};
    vecs[4] = '{1'b0, 1'b1, 1'b0, SIZE_BYTE, 32'h0000_0003, 32'h0, 4,
                32'h0000_00AB, 1'b0, SIZE_BYTE, 32'h0, 32'h0000_00AB};
    vecs[5] = '{1'b1, 1'b0, 1'b0, SIZE_HALF, 32'h0000_0004, 32'h55, 1,
                32'h0BAD_F00D, 1'b0, SIZE_WORD, 32'h0, 32'h0BAD_F00D};

    reset = 1'b0;
    if_req_i = 1'b1; if_addr_i = 32'h100;
    d_req_i = 1'b1; d_we_i = 1'b1; d_addr_i = 32'h200;
    d_wdata_i = 32'h33; d_size_i = SIZE_WORD;
    mem_rvalid_i = 1'b1; mem_rdata_i = 32'h4444;
    @(negedge clk);
    chk("rst.mem_req", 32'(mem_req_o), 32'd0);
    chk("rst.gnt", 32'({if_gnt_o, d_gnt_o}), 32'd0);
    chk("rst.mem_addr", mem_addr_o, 32'h0);
    chk("rst.mem_wdata", mem_wdata_o, 32'h0);
    chk("rst.rvalid", 32'({if_rvalid_o, d_rvalid_o}), 32'd0);
    chk("rst.busy_err", 32'({busy_o, err_o}), 32'd0);
    tick();
    if_req_i = 1'b0; d_req_i = 1'b0; mem_rvalid_i = 1'b0;
    tick();
    reset = 1'b1;

    foreach (vecs[i]) run_vec(i, vecs[i]);

    // Simultaneous fetch and load: data first, fetch right after.
    tick();
    if_req_i = 1'b1; if_addr_i = 32'h100;
    d_req_i = 1'b1; d_we_i = 1'b0; d_addr_i = 32'h2000;
    d_size_i = SIZE_WORD; d_wdata_i = 32'h0;
    @(negedge clk);
    chk("sim.d_gnt", 32'(d_gnt_o), 32'd1);
    chk("sim.if_gnt0", 32'(if_gnt_o), 32'd0);
    chk("sim.addr0", mem_addr_o, 32'h2000);
    tick();
    d_req_i = 1'b0; mem_rvalid_i = 1'b1; mem_rdata_i = 32'hAAAA_0001;
    @(negedge clk);
    chk("sim.d_rvalid", 32'(d_rvalid_o), 32'd1);
    chk("sim.d_rdata", d_rdata_o, 32'hAAAA_0001);
    tick();
    mem_rvalid_i = 1'b0;
    @(negedge clk);
    chk("sim.if_gnt1", 32'(if_gnt_o), 32'd1);
    chk("sim.addr1", mem_addr_o, 32'h100);
    tick();
    if_req_i = 1'b0; mem_rvalid_i = 1'b1; mem_rdata_i = 32'hBBBB_0002;
    @(negedge clk);
    chk("sim.if_rdata", if_rdata_o, 32'hBBBB_0002);
    tick();
    mem_rvalid_i = 1'b0;

    // Starvation: both held high, memory answers at once.
    if_req_i = 1'b1; d_req_i = 1'b1;
    mem_rvalid_i = 1'b1; mem_rdata_i = 32'h55;
    for (int k = 0; k < 10; k++) begin
      logic exp_d;
      exp_d = ((k % 5) != 4);
      @(negedge clk);
      chk($sformatf("starve.d_gnt%0d", k), 32'(d_gnt_o), 32'(exp_d));
      chk($sformatf("starve.if_gnt%0d", k), 32'(if_gnt_o), 32'(!exp_d));
      tick();
      if (k == 9) if_req_i = 1'b0;
      @(negedge clk);
      chk($sformatf("starve.rv%0d", k),
          32'({if_rvalid_o, d_rvalid_o}), exp_d ? 32'd1 : 32'd2);
      tick();
    end
    @(negedge clk);
    chk("starve.d_gnt_last", 32'(d_gnt_o), 32'd1);
    tick();
    d_req_i = 1'b0;
    @(negedge clk);
    chk("starve.d_rv_last", 32'(d_rvalid_o), 32'd1);
    tick();
    mem_rvalid_i = 1'b0;
    @(negedge clk);
    chk("starve.idle", 32'(busy_o), 32'd0);

    // Timeout on a load; late response afterwards is ignored.
    tick();
    d_req_i = 1'b1; d_we_i = 1'b0; d_addr_i = 32'h500;
    mem_rdata_i = 32'hCAFE;
    @(negedge clk);
    chk("to.d_gnt", 32'(d_gnt_o), 32'd1);
    for (int k = 1; k <= 15; k++) begin
      tick();
      if (k == 1) d_req_i = 1'b0;
      @(negedge clk);
      chk($sformatf("to.wait%0d", k),
          32'({err_o, d_rvalid_o, busy_o}), 32'd1);
    end
    tick();
    @(negedge clk);
    chk("to.err", 32'(err_o), 32'd1);
    chk("to.d_rvalid", 32'(d_rvalid_o), 32'd1);
    chk("to.d_rdata", d_rdata_o, 32'h0);
    tick();
    mem_rvalid_i = 1'b1;
    @(negedge clk);
    chk("to.late", 32'({err_o, busy_o, if_rvalid_o, d_rvalid_o}), 32'd0);
    chk("to.late_rdata", d_rdata_o | if_rdata_o, 32'h0);
    tick();
    mem_rvalid_i = 1'b0;

    // Response on the very last wait cycle beats the timeout.
    tick();
    if_req_i = 1'b1; if_addr_i = 32'h800;
    @(negedge clk);
    chk("tie.if_gnt", 32'(if_gnt_o), 32'd1);
    for (int k = 1; k <= 15; k++) begin
      tick();
      if (k == 1) if_req_i = 1'b0;
    end
    tick();
    mem_rvalid_i = 1'b1; mem_rdata_i = 32'h600D;
    @(negedge clk);
    chk("tie.err", 32'(err_o), 32'd0);
    chk("tie.if_rvalid", 32'(if_rvalid_o), 32'd1);
    chk("tie.if_rdata", if_rdata_o, 32'h600D);
    tick();
    mem_rvalid_i = 1'b0;

    // Reset in the middle of a data wait.
    tick();
    d_req_i = 1'b1; d_we_i = 1'b1; d_addr_i = 32'h900;
    d_wdata_i = 32'h11; d_size_i = SIZE_WORD;
    @(negedge clk);
    chk("rmw.d_gnt", 32'(d_gnt_o), 32'd1);
    tick();
    d_req_i = 1'b0;
    @(negedge clk);
    chk("rmw.busy", 32'(busy_o), 32'd1);
    #1;
    reset = 1'b0; if_req_i = 1'b1; if_addr_i = 32'hA00;
    mem_rvalid_i = 1'b1; mem_rdata_i = 32'h7777;
    #1;
    chk("rmw.rst_out", 32'({busy_o, err_o, d_rvalid_o, if_rvalid_o,
                            if_gnt_o, mem_req_o}), 32'd0);
    tick();
    tick();
    reset = 1'b1;
    @(negedge clk);
    chk("rmw.if_gnt", 32'(if_gnt_o), 32'd1);
    chk("rmw.addr", mem_addr_o, 32'hA00);
    chk("rmw.stale", 32'({if_rvalid_o, d_rvalid_o}), 32'd0);
    tick();
    if_req_i = 1'b0;
    @(negedge clk);
    chk("rmw.if_rvalid", 32'(if_rvalid_o), 32'd1);
    chk("rmw.if_rdata", if_rdata_o, 32'h7777);
    tick();
    mem_rvalid_i = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
